// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// One transaction in flight; memory-side command outputs are registered.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    r0_req,
    input  logic                    r0_we,
    input  logic [ADDR_WIDTH-1:0]   r0_addr,
    input  logic [2*DATA_WIDTH-1:0] r0_wdata,
    output logic                    r0_gnt,
    output logic                    r0_rvalid,
    output logic [DATA_WIDTH-1:0]   r0_rdata,
    input  logic                    r1_req,
    input  logic                    r1_we,
    input  logic [ADDR_WIDTH-1:0]   r1_addr,
    input  logic [2*DATA_WIDTH-1:0] r1_wdata,
    output logic                    r1_gnt,
    output logic                    r1_rvalid,
    output logic [DATA_WIDTH-1:0]   r1_rdata,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_w_addr,
    output logic [ADDR_WIDTH-1:0]   mem_r_addr,
    output logic [2*DATA_WIDTH-1:0] mem_w_data,
    input  logic [DATA_WIDTH-1:0]   mem_r_data,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    sel_q, sel_d;
    logic                    last_q, last_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_w_addr_q, mem_w_addr_d;
    logic [ADDR_WIDTH-1:0]   mem_r_addr_q, mem_r_addr_d;
    logic [2*DATA_WIDTH-1:0] mem_w_data_q, mem_w_data_d;

    logic [1:0]              req_vec;
    logic [1:0]              we_vec;
    logic [ADDR_WIDTH-1:0]   addr_arr  [2];
    logic [2*DATA_WIDTH-1:0] wdata_arr [2];
    logic [1:0]              gnt_vec;
    logic [1:0]              rvalid_vec;
    logic [DATA_WIDTH-1:0]   rdata_arr [2];
    logic                    win;

    assign req_vec      = {r1_req, r0_req};
    assign we_vec       = {r1_we, r0_we};
    assign addr_arr[0]  = r0_addr;
    assign addr_arr[1]  = r1_addr;
    assign wdata_arr[0] = r0_wdata;
    assign wdata_arr[1] = r1_wdata;

    // Per-requester response decode; only the selected port ever sees data.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic IDX = (gi == 1);
            assign gnt_vec[gi]    = (state_q == ISSUE) && (sel_q == IDX);
            assign rvalid_vec[gi] = (state_q == RESP) && (sel_q == IDX);
            assign rdata_arr[gi]  = rvalid_vec[gi] ? mem_r_data : '0;
        end
    endgenerate

    // On a tie the requester not served last wins.
    always_comb begin
        win = req_vec[1];
        if (&req_vec) begin
            win = ~last_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_d       = last_q;
        mem_we_d     = mem_we_q;
        mem_w_addr_d = mem_w_addr_q;
        mem_r_addr_d = mem_r_addr_q;
        mem_w_data_d = mem_w_data_q;
        case (state_q)
            IDLE: begin
                mem_we_d = 1'b0;
                if (|req_vec) begin
                    mem_we_d     = we_vec[win];
                    mem_w_addr_d = addr_arr[win];
                    mem_r_addr_d = addr_arr[win];
                    mem_w_data_d = wdata_arr[win];
                    sel_d        = win;
                    last_d       = win;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                mem_we_d = 1'b0;
                state_d  = mem_we_q ? IDLE : RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                mem_we_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            last_q       <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_w_addr_q <= '0;
            mem_r_addr_q <= '0;
            mem_w_data_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            mem_we_q     <= mem_we_d;
            mem_w_addr_q <= mem_w_addr_d;
            mem_r_addr_q <= mem_r_addr_d;
            mem_w_data_q <= mem_w_data_d;
        end
    end

    assign r0_gnt     = gnt_vec[0];
    assign r1_gnt     = gnt_vec[1];
    assign r0_rvalid  = rvalid_vec[0];
    assign r1_rvalid  = rvalid_vec[1];
    assign r0_rdata   = rdata_arr[0];
    assign r1_rdata   = rdata_arr[1];
    assign mem_we     = mem_we_q;
    assign mem_w_addr = mem_w_addr_q;
    assign mem_r_addr = mem_r_addr_q;
    assign mem_w_data = mem_w_data_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte memory with registered read, a cycle-indexed
// schedule of expected outputs, and directed transactions with literal checks.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        preload = 1'b1;
    logic        r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
    logic [7:0]  r0_addr = '0, r1_addr = '0;
    logic [15:0] r0_wdata = '0, r1_wdata = '0;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [7:0]  r0_rdata, r1_rdata;
    logic        mem_we, busy;
    logic [7:0]  mem_w_addr, mem_r_addr;
    logic [15:0] mem_w_data;
    logic [7:0]  mem_rd_q;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_we(mem_we), .mem_w_addr(mem_w_addr), .mem_r_addr(mem_r_addr),
        .mem_w_data(mem_w_data), .mem_r_data(mem_rd_q), .busy(busy)
    );

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            2:       return 8'd3;
            15:      return 8'd1;
            21:      return 8'd7;
            default: return 8'd0;
        endcase
    endfunction

    // Single-port memory: 16-bit write to addr/addr+1, registered read otherwise.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
            mem_rd_q <= '0;
        end else if (mem_we) begin
            mem[mem_w_addr]              <= mem_w_data[7:0];
            mem[8'(mem_w_addr + 8'd1)]   <= mem_w_data[15:8];
        end else begin
            mem_rd_q <= mem[mem_r_addr];
        end
    end

    // Reference model: a schedule of expected outputs per cycle index.
    logic [7:0]  ref_mem [256];
    logic        e_busy [64];
    logic [1:0]  e_gnt  [64];
    logic [1:0]  e_rv   [64];
    logic [7:0]  e_rd   [64];
    logic        e_we   [64];
    logic [7:0]  e_addr [64];
    logic [15:0] e_wd   [64];
    logic        c_en   [64];
    logic [7:0]  c_addr [64];
    logic [15:0] c_data [64];
    logic        last_m;
    int          free_at;
    int          nx;
    logic [5:0]  s0, s1, s3, sc;
    logic        win_m, we_w;
    logic [7:0]  addr_w;
    logic [15:0] wd_w;

    assign nx     = cyc + 1;
    assign s0     = 6'(nx);
    assign s1     = 6'(nx + 1);
    assign s3     = 6'(nx + 3);
    assign sc     = 6'(cyc);
    assign win_m  = (r0_req && r1_req) ? !last_m : r1_req;
    assign we_w   = win_m ? r1_we : r0_we;
    assign addr_w = win_m ? r1_addr : r0_addr;
    assign wd_w   = win_m ? r1_wdata : r0_wdata;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                e_busy[i] <= 1'b0; e_gnt[i] <= '0; e_rv[i] <= '0; e_rd[i] <= '0;
                e_we[i] <= 1'b0; e_addr[i] <= '0; e_wd[i] <= '0;
                c_en[i] <= 1'b0; c_addr[i] <= '0; c_data[i] <= '0;
            end
            last_m  <= 1'b1;
            free_at <= 0;
            if (preload) begin
                for (int i = 0; i < 256; i++) ref_mem[i] <= init_byte(i);
            end
        end else begin
            cyc <= nx;
            e_busy[s3] <= 1'b0; e_gnt[s3] <= '0; e_rv[s3] <= '0; e_rd[s3] <= '0;
            e_we[s3] <= 1'b0; c_en[s3] <= 1'b0;
            if (c_en[s0]) begin
                ref_mem[c_addr[s0]]            <= c_data[s0][7:0];
                ref_mem[8'(c_addr[s0] + 8'd1)] <= c_data[s0][15:8];
            end
            if (nx >= free_at && (r0_req || r1_req)) begin
                last_m     <= win_m;
                e_busy[s0] <= 1'b1;
                e_gnt[s0]  <= win_m ? 2'b10 : 2'b01;
                e_we[s0]   <= we_w;
                e_addr[s0] <= addr_w;
                e_wd[s0]   <= wd_w;
                if (we_w) begin
                    c_en[s1]   <= 1'b1;
                    c_addr[s1] <= addr_w;
                    c_data[s1] <= wd_w;
                    free_at    <= nx + 2;
                end else begin
                    e_busy[s1] <= 1'b1;
                    e_rv[s1]   <= win_m ? 2'b10 : 2'b01;
                    e_rd[s1]   <= ref_mem[addr_w];
                    free_at    <= nx + 3;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("rst_outputs",
                  32'({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we, busy}), 32'd0);
            check("rst_rdata", 32'({r0_rdata, r1_rdata}), 32'd0);
            check("rst_mem_addr", 32'({mem_w_addr, mem_r_addr}), 32'd0);
            check("rst_mem_wdata", 32'(mem_w_data), 32'd0);
        end else begin
            check("gnt", 32'({r1_gnt, r0_gnt}), 32'(e_gnt[sc]));
            check("rvalid", 32'({r1_rvalid, r0_rvalid}), 32'(e_rv[sc]));
            check("r0_rdata", 32'(r0_rdata), 32'(e_rv[sc][0] ? e_rd[sc] : 8'h00));
            check("r1_rdata", 32'(r1_rdata), 32'(e_rv[sc][1] ? e_rd[sc] : 8'h00));
            check("busy", 32'(busy), 32'(e_busy[sc]));
            check("mem_we", 32'(mem_we), 32'((e_gnt[sc] != 2'b00) && e_we[sc]));
            if (e_gnt[sc] != 2'b00) begin
                if (e_we[sc]) begin
                    check("mem_w_addr", 32'(mem_w_addr), 32'(e_addr[sc]));
                    check("mem_w_data", 32'(mem_w_data), 32'(e_wd[sc]));
                end else begin
                    check("mem_r_addr", 32'(mem_r_addr), 32'(e_addr[sc]));
                end
            end
        end
    end

    task automatic set_req(input int who, input logic req, input logic we,
                           input logic [7:0] addr, input logic [15:0] wd);
        if (who == 0) begin
            r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wd;
        end else begin
            r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wd;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_txn(input int who, input logic we, input logic [7:0] addr,
                          input logic [15:0] wd, output logic [7:0] rd,
                          output int lat, output logic we_seen);
        logic g;
        g = 1'b0;
        lat = 0;
        rd = '0;
        we_seen = 1'b0;
        set_req(who, 1'b1, we, addr, wd);
        while (!g && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            g = (who == 0) ? r0_gnt : r1_gnt;
        end
        we_seen = mem_we;
        if (!g) check("gnt_timeout", 32'(g), 32'd1);
        set_req(who, 1'b0, we, addr, wd);
        if (g && !we) begin
            @(posedge clk);
            #1;
            check("txn_rvalid", 32'((who == 0) ? r0_rvalid : r1_rvalid), 32'd1);
            rd = (who == 0) ? r0_rdata : r1_rdata;
        end
        $display("txn r%0d we=%0d addr=%02h wdata=%04h lat=%0d rdata=%02h",
                 who, we, addr, wd, lat, rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd0, rd1;
        int         lat0, lat1, n, cycles;
        logic       ws0, ws1;

        idle(3);
        preload = 1'b0;
        reset = 1'b0;
        idle(1);

        // Tie right after reset: r0 first, then r1; a second tie again favours r0.
        for (int p = 0; p < 2; p++) begin
            fork
                do_txn(0, 1'b0, 8'h0F, 16'h0, rd0, lat0, ws0);
                do_txn(1, 1'b0, 8'h15, 16'h0, rd1, lat1, ws1);
            join
            check("tie_r0_data", 32'(rd0), 32'h01);
            check("tie_r1_data", 32'(rd1), 32'h07);
            check("tie_r0_lat", 32'(lat0), 32'd1);
            check("tie_r1_lat", 32'(lat1), 32'd4);
            idle(1);
        end

        // Write then read back both bytes.
        do_txn(0, 1'b1, 8'h20, 16'h0B0A, rd0, lat0, ws0);
        check("wr_lat", 32'(lat0), 32'd1);
        check("wr_mem_we_with_gnt", 32'(ws0), 32'd1);
        idle(1);
        do_txn(1, 1'b0, 8'h20, 16'h0, rd1, lat1, ws1);
        check("rd_20", 32'(rd1), 32'h0A);
        idle(1);
        do_txn(1, 1'b0, 8'h21, 16'h0, rd1, lat1, ws1);
        check("rd_21", 32'(rd1), 32'h0B);
        idle(1);

        // Preloaded byte.
        do_txn(1, 1'b0, 8'h02, 16'h0, rd1, lat1, ws1);
        check("preload_lat", 32'(lat1), 32'd1);
        check("preload_data", 32'(rd1), 32'h03);
        idle(1);

        // Write at top address wraps the high byte to address 0.
        do_txn(0, 1'b1, 8'hFF, 16'h5566, rd0, lat0, ws0);
        idle(1);
        do_txn(1, 1'b0, 8'h00, 16'h0, rd1, lat1, ws1);
        check("wrap_rd_00", 32'(rd1), 32'h55);
        idle(1);
        do_txn(0, 1'b0, 8'hFF, 16'h0, rd0, lat0, ws0);
        check("wrap_rd_ff", 32'(rd0), 32'h66);
        idle(1);

        // r0 streams writes with req held; r1 must still get in promptly.
        fork
            begin
                n = 0;
                cycles = 0;
                set_req(0, 1'b1, 1'b1, 8'h40, 16'h1000);
                while (n < 6 && cycles < 60) begin
                    @(posedge clk);
                    #1;
                    cycles++;
                    if (r0_gnt) begin
                        $display("txn r0 stream write %0d granted at cycle %0d", n, cyc);
                        n++;
                        set_req(0, 1'b1, 1'b1, 8'(8'h40 + 2 * n), 16'(16'h1000 + n));
                    end
                end
                set_req(0, 1'b0, 1'b0, 8'h00, 16'h0);
                check("stream_count", 32'(n), 32'd6);
            end
            begin
                idle(3);
                do_txn(1, 1'b0, 8'h80, 16'h0, rd1, lat1, ws1);
                check("starve_lat_le2", 32'(lat1 <= 2), 32'd1);
                check("starve_data", 32'(rd1), 32'h00);
            end
        join
        idle(1);

        // Reset during ISSUE with r0_req still high, then a clean restart.
        set_req(0, 1'b1, 1'b0, 8'h0F, 16'h0);
        idle(1);
        check("pre_rst_gnt", 32'(r0_gnt), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_issue_gnt", 32'(r0_gnt), 32'd0);
        check("rst_issue_busy", 32'(busy), 32'd0);
        idle(1);
        reset = 1'b0;
        lat0 = 0;
        ws0 = 1'b0;
        while (!ws0 && lat0 < 20) begin
            @(posedge clk);
            #1;
            lat0++;
            ws0 = r0_gnt;
        end
        check("post_rst_lat", 32'(lat0), 32'd1);
        set_req(0, 1'b0, 1'b0, 8'h0F, 16'h0);
        idle(1);
        check("post_rst_rdata", 32'(r0_rdata), 32'h01);
        $display("txn r0 read after reset lat=%0d rdata=%02h", lat0, r0_rdata);
        idle(1);

        // Reset during RESP drops the response at once.
        set_req(1, 1'b1, 1'b0, 8'h15, 16'h0);
        idle(1);
        check("resp_case_gnt", 32'(r1_gnt), 32'd1);
        set_req(1, 1'b0, 1'b0, 8'h15, 16'h0);
        idle(1);
        check("resp_case_rvalid", 32'(r1_rvalid), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_resp_rvalid", 32'(r1_rvalid), 32'd0);
        check("rst_resp_busy", 32'(busy), 32'd0);
        check("rst_resp_rdata", 32'(r1_rdata), 32'd0);
        $display("txn r1 read aborted by reset in response cycle");
        idle(1);
        reset = 1'b0;
        idle(1);
        fork
            do_txn(0, 1'b0, 8'h15, 16'h0, rd0, lat0, ws0);
            do_txn(1, 1'b0, 8'h0F, 16'h0, rd1, lat1, ws1);
        join
        check("rst2_tie_r0_lat", 32'(lat0), 32'd1);
        check("rst2_tie_r1_lat", 32'(lat1), 32'd4);
        check("rst2_r0_data", 32'(rd0), 32'h07);
        check("rst2_r1_data", 32'(rd1), 32'h01);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
